// File: rtl/scope_pkg.sv
// Shared types and constants for the trace capture path feeding the VGA display.
// Samples are packed {volts[3:0], tenths[3:0]}, so unsigned compares follow voltage order.
package scope_pkg;

  localparam int N_COLS = 640;
  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] FULL_SCALE = 8'h59;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } cap_state_e;

  // Out-of-range volts saturate the whole sample; a bad tenths digit pins to 9.
  function automatic logic [SAMPLE_W-1:0] sanitise_sample(input logic [SAMPLE_W-1:0] raw);
    logic [SAMPLE_W-1:0] s;
    if (raw[7:4] > 4'd5) begin
      s = FULL_SCALE;
    end else if (raw[3:0] > 4'd9) begin
      s = {raw[7:4], 4'd9};
    end else begin
      s = raw;
    end
    return s;
  endfunction

endpackage

// File: rtl/capture_bank_ram.sv
// Ping-pong record store: two banks of N_COLS samples, one write port and one
// registered read port; the caller picks which bank each port targets.
module capture_bank_ram
  import scope_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic                wr_bank,
  input  logic [9:0]          wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_bank,
  input  logic [9:0]          rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem_q [0:1][0:N_COLS-1];
  logic [SAMPLE_W-1:0] rd_data_q;

  // Storage write and synchronous read; contents deliberately carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_bank][wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_bank][rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_capture.sv
// Decimates the ADC stream, arms on a level/slope trigger and captures one
// display-width record into the back bank; banks swap only on frame_sync.
module trace_capture
  import scope_pkg::*;
#(
  parameter int DECIM        = 1,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  input  logic                auto_mode,
  input  logic                hold,
  input  logic                frame_sync,
  input  logic [9:0]          rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                capture_busy,
  output logic                triggered,
  output logic                front_valid
);

  localparam int TO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [7:0]      DECIM_M1 = 8'(DECIM - 1);
  localparam logic [9:0]      LAST_COL = 10'(N_COLS - 1);

  cap_state_e          state_q, state_d;
  logic                bank_sel_q, bank_sel_d;
  logic                front_valid_q, front_valid_d;
  logic                capture_busy_q, capture_busy_d;
  logic                triggered_q, triggered_d;
  logic                rd_ok_q, rd_ok_d;
  logic [7:0]          dec_cnt_q, dec_cnt_d;
  logic [9:0]          wr_addr_q, wr_addr_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;

  logic [SAMPLE_W-1:0] cur_s, ram_rd_s;
  logic                accepted_s, hit_s, forced_s, we_s;
  logic [9:0]          waddr_s, rd_idx_s;

  assign cur_s = sanitise_sample(sample_in);

  // Next-state: decimation, trigger detect, capture sequencing and bank swap.
  always_comb begin
    state_d       = state_q;
    bank_sel_d    = bank_sel_q;
    front_valid_d = front_valid_q;
    dec_cnt_d     = dec_cnt_q;
    wr_addr_d     = wr_addr_q;
    to_cnt_d      = to_cnt_q;
    prev_d        = prev_q;
    triggered_d   = 1'b0;
    we_s          = 1'b0;
    waddr_s       = wr_addr_q;

    if (sample_valid) begin
      dec_cnt_d = (dec_cnt_q == DECIM_M1) ? 8'd0 : dec_cnt_q + 8'd1;
    end else begin
      dec_cnt_d = dec_cnt_q;
    end
    accepted_s = sample_valid && (dec_cnt_q == 8'd0);

    if (trig_slope) begin
      hit_s = (prev_q > trig_level) && (cur_s <= trig_level);
    end else begin
      hit_s = (prev_q < trig_level) && (cur_s >= trig_level);
    end
    forced_s = auto_mode && (to_cnt_q == TO_LAST);

    case (state_q)
      ARM: begin
        if (accepted_s) begin
          prev_d   = cur_s;
          to_cnt_d = '0;
          state_d  = WAIT_TRIG;
        end else begin
          state_d = ARM;
        end
      end
      WAIT_TRIG: begin
        if (accepted_s) begin
          prev_d = cur_s;
          if (hit_s || forced_s) begin
            we_s        = 1'b1;
            waddr_s     = 10'd0;
            triggered_d = 1'b1;
            wr_addr_d   = 10'd1;
            state_d     = CAPTURE;
          end else if (to_cnt_q != {TO_W{1'b1}}) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end else begin
            to_cnt_d = to_cnt_q;
          end
        end else begin
          state_d = WAIT_TRIG;
        end
      end
      CAPTURE: begin
        if (accepted_s) begin
          we_s = 1'b1;
          if (wr_addr_q == LAST_COL) begin
            wr_addr_d = 10'd0;
            state_d   = DONE;
          end else begin
            wr_addr_d = wr_addr_q + 10'd1;
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      DONE: begin
        if (frame_sync && !hold) begin
          bank_sel_d    = ~bank_sel_q;
          front_valid_d = 1'b1;
          state_d       = ARM;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = ARM;
      end
    endcase

    capture_busy_d = (state_d == WAIT_TRIG) || (state_d == CAPTURE);
    // Out-of-range columns are masked at the output, so any legal RAM index will do.
    rd_ok_d  = front_valid_q && (rd_addr < 10'(N_COLS));
    rd_idx_s = (rd_addr < 10'(N_COLS)) ? rd_addr : 10'd0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ARM;
      bank_sel_q     <= 1'b0;
      front_valid_q  <= 1'b0;
      capture_busy_q <= 1'b0;
      triggered_q    <= 1'b0;
      rd_ok_q        <= 1'b0;
      dec_cnt_q      <= 8'd0;
      wr_addr_q      <= 10'd0;
      to_cnt_q       <= '0;
      prev_q         <= '0;
    end else begin
      state_q        <= state_d;
      bank_sel_q     <= bank_sel_d;
      front_valid_q  <= front_valid_d;
      capture_busy_q <= capture_busy_d;
      triggered_q    <= triggered_d;
      rd_ok_q        <= rd_ok_d;
      dec_cnt_q      <= dec_cnt_d;
      wr_addr_q      <= wr_addr_d;
      to_cnt_q       <= to_cnt_d;
      prev_q         <= prev_d;
    end
  end

  capture_bank_ram u_ram (
    .clk     (clk),
    .we      (we_s),
    .wr_bank (~bank_sel_q),
    .wr_addr (waddr_s),
    .wr_data (cur_s),
    .rd_bank (bank_sel_q),
    .rd_addr (rd_idx_s),
    .rd_data (ram_rd_s)
  );

  assign rd_data      = rd_ok_q ? ram_rd_s : 8'h00;
  assign capture_busy = capture_busy_q;
  assign triggered    = triggered_q;
  assign front_valid  = front_valid_q;

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: a DECIM=1 and a DECIM=4 instance share stimulus.
module tb_trace_capture;
  import scope_pkg::*;

  logic       clk = 1'b0;
  logic       rst, sample_valid, trig_slope, auto_mode, hold, frame_sync;
  logic [7:0] sample_in, trig_level;
  logic [9:0] rd_addr;
  logic [7:0] rd_data1, rd_data4;
  logic       busy1, trig1, fv1, busy4, trig4, fv4;

  always #5 clk = ~clk;

  trace_capture #(.DECIM(1), .AUTO_TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .trig_level(trig_level), .trig_slope(trig_slope), .auto_mode(auto_mode),
    .hold(hold), .frame_sync(frame_sync), .rd_addr(rd_addr), .rd_data(rd_data1),
    .capture_busy(busy1), .triggered(trig1), .front_valid(fv1));

  trace_capture #(.DECIM(4), .AUTO_TIMEOUT(16)) dut4 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .trig_level(trig_level), .trig_slope(trig_slope), .auto_mode(auto_mode),
    .hold(hold), .frame_sync(frame_sync), .rd_addr(rd_addr), .rd_data(rd_data4),
    .capture_busy(busy4), .triggered(trig4), .front_valid(fv4));

  typedef struct {
    logic [7:0] exp;
    bit         sel;
    string      name;
  } sb_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] exp;
    string      name;
  } rd_vec_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cur_k = 0;
  int  trig1_cnt, trig1_at, trig4_cnt, trig4_at;

  function automatic logic [7:0] tenth_byte(input int t);
    int c;
    c = (t > 59) ? 59 : ((t < 0) ? 0 : t);
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [7:0] ramp_val(input int k);
    return tenth_byte(20 + k);
  endfunction

  function automatic logic [7:0] fall_val(input int i);
    return (i < 10) ? 8'h40 : tenth_byte((i * 7) % 30);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    if (trig1) begin trig1_cnt++; trig1_at = cur_k; end
    if (trig4) begin trig4_cnt++; trig4_at = cur_k; end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, e.sel ? rd_data4 : rd_data1, e.exp);
    end
  endtask

  task automatic rd_issue(input logic [9:0] a, input logic [7:0] exp, input bit sel, input string nm);
    sb_t e;
    rd_addr = a;
    e.exp = exp; e.sel = sel; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic rd(input logic [9:0] a, input logic [7:0] exp, input bit sel, input string nm);
    rd_issue(a, exp, sel, nm);
    tick();
  endtask

  task automatic feed(input logic [7:0] v, input int k);
    sample_valid = 1'b1;
    sample_in    = v;
    cur_k        = k;
    tick();
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_fs();
    sample_valid = 1'b0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    trig1_cnt = 0; trig4_cnt = 0; trig1_at = -1; trig4_at = -1;
  endtask

  initial begin
    rd_vec_t ramp_vecs[8];
    rst = 1'b1; sample_valid = 1'b0; sample_in = 8'h00; trig_level = 8'h25;
    trig_slope = 1'b0; auto_mode = 1'b0; hold = 1'b0; frame_sync = 1'b0; rd_addr = 10'd5;
    trig1_cnt = 0; trig4_cnt = 0; trig1_at = -1; trig4_at = -1;

    // Reset state, then asynchronous reset in the middle of a stream.
    tick(); tick();
    chk("rst_rd_data", rd_data1, 8'h00);
    chk("rst_front_valid", fv1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_triggered", trig1, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) feed(8'h20, k);
    chk("busy_before_rst", busy1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy1, 1'b0);
    chk("async_rst_fv", fv1, 1'b0);
    chk("async_rst_rd", rd_data1, 8'h00);
    tick();
    rst = 1'b0;
    idle(1);
    chk("post_rst_idle_busy", busy1, 1'b0);
    feed(8'h20, 0);
    chk("post_rst_arm_accept", busy1, 1'b1);

    // Rising trigger on a ramp, DECIM=1.
    do_reset();
    trig_level = 8'h25; trig_slope = 1'b0;
    for (int k = 0; k < 650; k++) begin
      frame_sync = (k == 300 || k == 644);
      feed(ramp_val(k), k);
      if (k == 100) chk("ramp_busy_mid", busy1, 1'b1);
    end
    frame_sync = 1'b0;
    chk("ramp_trig_count", trig1_cnt, 1);
    chk("ramp_trig_at", trig1_at, 5);
    chk("ramp_done_busy", busy1, 1'b0);
    chk("ramp_fv_before_swap", fv1, 1'b0);
    idle(1);
    rd(10'd0, 8'h00, 1'b0, "ramp_rd_before_swap");
    pulse_fs();
    chk("ramp_fv_after_swap", fv1, 1'b1);
    ramp_vecs[0] = '{10'd0,    ramp_val(5),  "ramp_rd0"};
    ramp_vecs[1] = '{10'd1,    ramp_val(6),  "ramp_rd1"};
    ramp_vecs[2] = '{10'd9,    ramp_val(14), "ramp_rd9"};
    ramp_vecs[3] = '{10'd34,   8'h59,        "ramp_rd34"};
    ramp_vecs[4] = '{10'd639,  8'h59,        "ramp_rd639"};
    ramp_vecs[5] = '{10'd640,  8'h00,        "ramp_rd640"};
    ramp_vecs[6] = '{10'd700,  8'h00,        "ramp_rd700"};
    ramp_vecs[7] = '{10'd1023, 8'h00,        "ramp_rd1023"};
    for (int i = 0; i < 8; i++) rd(ramp_vecs[i].addr, ramp_vecs[i].exp, 1'b0, ramp_vecs[i].name);

    // Falling trigger, DECIM=4, with idle cycles between strobes.
    do_reset();
    trig_level = 8'h30; trig_slope = 1'b1;
    for (int i = 0; i < 2572; i++) begin
      feed(fall_val(i), i);
      if (i % 3 == 2) idle(1);
    end
    sample_valid = 1'b0;
    chk("fall_trig_count", trig4_cnt, 1);
    chk("fall_trig_at", trig4_at, 12);
    chk("fall_fv_before", fv4, 1'b0);
    pulse_fs();
    chk("fall_fv_after", fv4, 1'b1);
    foreach (ramp_vecs[i]) begin
      int j;
      j = (i < 4) ? i : ((i == 4) ? 100 : ((i == 5) ? 638 : ((i == 6) ? 639 : 320)));
      rd(10'(j), fall_val(12 + 4 * j), 1'b1, "fall_rd");
    end

    // Auto-timeout forced trigger on a flat signal.
    do_reset();
    trig_level = 8'h40; trig_slope = 1'b0; auto_mode = 1'b1;
    for (int k = 0; k < 660; k++) feed(8'h10, k);
    sample_valid = 1'b0;
    chk("auto_trig_count", trig1_cnt, 1);
    chk("auto_trig_at", trig1_at, 16);
    pulse_fs();
    chk("auto_fv", fv1, 1'b1);
    rd(10'd0,   8'h10, 1'b0, "auto_rd0");
    rd(10'd320, 8'h10, 1'b0, "auto_rd320");
    rd(10'd639, 8'h10, 1'b0, "auto_rd639");

    // Hold blocks swaps; releasing it swaps exactly on the next frame_sync.
    auto_mode = 1'b0; trig_level = 8'h25; hold = 1'b1;
    trig1_cnt = 0;
    for (int k = 0; k < 650; k++) feed(ramp_val(k), k);
    chk("hold_trig_at", trig1_at, 5);
    for (int n = 0; n < 3; n++) begin
      pulse_fs();
      idle(2);
    end
    rd(10'd0,   8'h10, 1'b0, "hold_old_rd0");
    rd(10'd639, 8'h10, 1'b0, "hold_old_rd639");
    hold = 1'b0;
    frame_sync = 1'b1;
    rd_issue(10'd0, 8'h10, 1'b0, "swap_same_cycle_rd");
    tick();
    frame_sync = 1'b0;
    rd(10'd0,   8'h25, 1'b0, "swap_next_rd0");
    rd(10'd9,   8'h34, 1'b0, "swap_next_rd9");
    rd(10'd639, 8'h59, 1'b0, "swap_next_rd639");

    // Sanitised storage and reset during capture.
    feed(8'h20, 0);
    feed(8'h7A, 1);
    feed(8'h3C, 2);
    for (int k = 3; k <= 300; k++) feed(tenth_byte((k - 1) % 50), k);
    sample_valid = 1'b0;
    chk("midcap_busy", busy1, 1'b1);
    chk("midcap_fv_before", fv1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midcap_rst_fv", fv1, 1'b0);
    chk("midcap_rst_busy", busy1, 1'b0);
    tick();
    rst = 1'b0;
    trig1_cnt = 0;
    feed(8'h20, 0);
    feed(8'h7A, 1);
    feed(8'h3C, 2);
    for (int k = 3; k < 646; k++) feed(tenth_byte(((k - 1) * 3) % 50), k);
    sample_valid = 1'b0;
    chk("san_trig_at", trig1_at, 1);
    pulse_fs();
    chk("san_fv", fv1, 1'b1);
    rd(10'd0,   8'h59, 1'b0, "san_clamp_7A");
    rd(10'd1,   8'h39, 1'b0, "san_tenths_3C");
    rd(10'd2,   tenth_byte(6), 1'b0, "san_rd2");
    rd(10'd300, tenth_byte(900 % 50), 1'b0, "san_rd300");
    rd(10'd639, tenth_byte((639 * 3) % 50), 1'b0, "san_rd639");
    idle(2);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
